scan_display_ctrl: RTL
======================

Name: scan_display_ctrl

Overview:
- Parametrised multiplexed 7-segment scan controller; successor to the fixed two-digit display muxing in the top-level display block.
- Drives NUM_DIGITS common-enable digits from one clock, using an internal prescaler clock-enable instead of derived divider clocks.
- Adds per-frame shadow latching, per-digit enable, PWM brightness and a frame tick.
- Sits between the counter/decoder logic (speed, action, etc.) and the board seg/dig pins.

Parameters:
- NUM_DIGITS, 5, number of scanned digits (1..8).
- SCAN_W, 16, prescaler width; each digit slot lasts 2^SCAN_W clk_0 cycles.
- BRIGHT_W, 3, brightness code width (requires BRIGHT_W <= SCAN_W).
- SEG_ACTIVE_LOW, 0, 1 = seg outputs inverted (lit segment = 0).

Ports:
- clk_0  in  1  system clock
- rst_act  in  1  synchronous active-low reset
- power  in  1  1 = display on; 0 = all digits off
- digit_val  in  4*NUM_DIGITS  hex value per digit; digit i = bits [4i+3:4i]
- digit_en  in  NUM_DIGITS  1 = digit i shown; 0 = blanked
- brightness  in  BRIGHT_W  PWM duty code; all-ones = full on
- dig  out  NUM_DIGITS  digit enables, active-low (1 = off)
- seg  out  7  segments a..g on seg[0]..seg[6]; polarity per SEG_ACTIVE_LOW
- scan_idx  out  3  index of the digit currently being driven
- frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (rst_act=0 at clk_0 edge):
  - prescaler=0, scan_idx=0, frame_tick=0, dig=all 1.
  - seg=all unlit (7'h00, or 7'h7F if SEG_ACTIVE_LOW).
  - Shadow registers=0.
  - Reset mid-frame aborts the frame immediately.
- Prescaler: free-running SCAN_W-bit counter; wraps 2^SCAN_W-1 -> 0; slot_end when prescaler = all ones.
- On slot_end: scan_idx increments; NUM_DIGITS-1 wraps to 0.
  - On that wrap, frame_tick=1 for exactly the next cycle.
  - On that wrap, shadow_val<=digit_val, shadow_en<=digit_en, shadow_bright<=brightness.
  - First frame after reset displays zeros until the first wrap.
- Input changes mid-frame are never visible before the next frame (no tearing).
- PWM: lit = (prescaler[SCAN_W-1 -: BRIGHT_W] <= shadow_bright).
  - Code 0 lights 1/2^BRIGHT_W of the slot; all-ones lights the full slot.
- Output stage: dig and seg are registered; they reflect the scan_idx/prescaler state of the previous cycle (1-cycle latency).
  - dig[scan_idx]=0 only when power=1 AND shadow_en[scan_idx]=1 AND lit; all other dig bits=1.
  - seg = hex decode of shadow_val[scan_idx], polarity applied.
  - seg is forced unlit whenever no digit is enabled.
- Hex decode (a..g, active-high form):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- power=0: prescaler, scan_idx and frame_tick keep running; dig all 1, seg unlit. Restoring power resumes output at the current slot.
- Never more than one dig bit low in any cycle.
- At a slot boundary, the outgoing digit's dig goes high in the same cycle the new digit's seg pattern appears (no ghosting from the previous value).

Optional Feature:
- Macro: SCAN_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking, computed on the shadow registers at frame latch.
  - Starting from digit NUM_DIGITS-1 downward, each digit with value 0 is treated as disabled until the first nonzero digit.
  - Digit 0 is never blanked.
  - Example: 0,0,4,0 -> shows "  40".
- Undefined: every enabled digit shows its value, zeros included.

Test Plan (NUM_DIGITS=3, SCAN_W=4, BRIGHT_W=2, SEG_ACTIVE_LOW=0 unless stated):
- Reset: hold rst_act=0 for 3 cycles -> dig=3'b111, seg=7'h00, scan_idx=0, frame_tick=0; on release, scan_idx=1 after 16 cycles.
- Scan/frame: power=1, digit_val=12'h3A7, digit_en=3'b111, brightness=3 -> second frame onward shows seg 07 (dig=110), 77 (dig=101), 4F (dig=011), 16 cycles each; frame_tick pulses once every 48 cycles.
- Brightness: brightness=0 -> each digit's dig bit is low for exactly 4 of 16 cycles (prescaler 0..3, seen one cycle later); brightness=2 -> 12 of 16.
- Tearing/enable: change digit_val to 12'h000 at mid-frame with digit_en=3'b101 -> old values persist to frame end; next frame digit 1 stays dig=1, digits 0/2 show seg 3F.
- Power: power=0 for 20 cycles mid-slot -> dig=3'b111 and seg=7'h00 throughout; scan_idx continues advancing; power=1 -> output resumes at the current scan_idx.
- LZ blank (macro defined): digit_val=12'h005 -> only digit 0 lit (seg 6D); digit_val=12'h000 -> digit 0 shows 3F, digits 1 and 2 dark.

Source files
------------

// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit scan with frame shadow
// latch, PWM brightness and frame tick. Optional: SCAN_DISPLAY_LZ_BLANK_EN.
module scan_display_ctrl #(
  parameter int NUM_DIGITS     = 5,
  parameter int SCAN_W         = 16,
  parameter int BRIGHT_W       = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_0,
  input  logic                    rst_act,
  input  logic                    power,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [6:0]              seg,
  output logic [2:0]              scan_idx,
  output logic                    frame_tick
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [SCAN_W-1:0]       presc_q;
  logic [2:0]              idx_q;
  logic                    tick_q;
  logic [4*NUM_DIGITS-1:0] sh_val_q;
  logic [NUM_DIGITS-1:0]   sh_en_q;
  logic [BRIGHT_W-1:0]     sh_br_q;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic [6:0]              seg_q, seg_d;

  logic                    slot_end;
  logic                    last;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   en_latch;

  assign slot_end = &presc_q;
  assign last     = (idx_q == 3'(NUM_DIGITS - 1));
  assign wrap     = slot_end & last;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

`ifdef SCAN_DISPLAY_LZ_BLANK_EN
  // Enable mask to latch: leading zeros above digit 0 are masked off
  always_comb begin
    logic lead;
    en_latch = digit_en;
    lead     = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && digit_val[4*i +: 4] == 4'h0) en_latch[i] = 1'b0;
      else lead = 1'b0;
    end
  end
`else
  assign en_latch = digit_en;
`endif

  // Prescaler, scan index, frame tick and per-frame shadow latch
  always_ff @(posedge clk_0) begin
    if (!rst_act) begin
      presc_q  <= '0;
      idx_q    <= '0;
      tick_q   <= 1'b0;
      sh_val_q <= '0;
      sh_en_q  <= '0;
      sh_br_q  <= '0;
    end else begin
      presc_q <= presc_q + SCAN_W'(1);
      tick_q  <= wrap;
      if (slot_end) idx_q <= last ? 3'd0 : idx_q + 3'd1;
      if (wrap) begin
        sh_val_q <= digit_val;
        sh_en_q  <= en_latch;
        sh_br_q  <= brightness;
      end
    end
  end

  // Next digit/segment drive for the current slot and PWM phase
  always_comb begin
    logic [3:0]            cur_val;
    logic                  cur_en;
    logic [NUM_DIGITS-1:0] sel;
    logic                  lit;
    logic                  on;
    logic [6:0]            pat;
    cur_val = 4'h0;
    cur_en  = 1'b0;
    sel     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_val = sh_val_q[4*i +: 4];
        cur_en  = sh_en_q[i];
        sel[i]  = 1'b1;
      end
    end
    lit   = (presc_q[SCAN_W-1 -: BRIGHT_W] <= sh_br_q);
    on    = power & cur_en & lit;
    pat   = hex7(cur_val);
    dig_d = on ? ~sel : '1;
    seg_d = on ? (SEG_ACTIVE_LOW ? ~pat : pat) : SEG_OFF;
  end

  // Registered pin drive so dig and seg switch on the same edge
  always_ff @(posedge clk_0) begin
    if (!rst_act) begin
      dig_q <= '1;
      seg_q <= SEG_OFF;
    end else begin
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end

  assign dig        = dig_q;
  assign seg        = seg_q;
  assign scan_idx   = idx_q;
  assign frame_tick = tick_q;

endmodule
